lpc_stream_framer: RTL and testbench
====================================

Name: lpc_stream_framer

Overview:
Parametrised AXI-stream framer placed in front of lpc_encoder. It takes a raw PCM sample stream and buffers it in a small FIFO. Each output sample is tagged with TUSER (first sample of a stream) and TLAST (last sample of each FRAME_LEN-sample frame). A stream ended mid-frame is zero-padded to a whole frame, which replaces the fixed 1920-sample software tagging previously done outside the datapath.

Parameters:
DATA_W, 16, sample width in bits
FRAME_LEN, 1920, samples per frame (>=2)
DEPTH, 4, FIFO entries (power of 2, >=2)
PAD_VALUE, 0, DATA_W-bit value inserted during padding

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  reset; asynchronous, active-high
S_DATA  in  DATA_W  input sample
S_VALID  in  1  input sample valid
S_EOS  in  1  end-of-stream, qualified by S_VALID&S_READY
S_READY  out  1  framer can accept a sample
M_TDATA  out  DATA_W  output sample
M_TVALID  out  1  output valid
M_TREADY  in  1  downstream ready
M_TLAST  out  1  last sample of frame
M_TUSER  out  1  first sample of stream
FRAME_CNT  out  16  completed frames (handshakes with TLAST)
PADDING  out  1  high while in PAD state

Behaviour:
- Reset (async assert, sync deassert): FIFO empty, M_TVALID=0, M_TDATA=0, M_TLAST=0, M_TUSER=0, S_READY=0 during reset, FRAME_CNT=0, PADDING=0, idx=0, sof_pending=1, state=STREAM. Reset mid-frame discards all buffered data; no partial frame is emitted.
- Write side tags each entry as {data, first, last}:
  - first = sof_pending; sof_pending clears on the write.
  - last = (idx==FRAME_LEN-1).
  - idx increments per write and wraps to 0 after FRAME_LEN-1. idx width is $clog2(FRAME_LEN).
- State STREAM: S_READY = !full. A write occurs on S_VALID&S_READY.
  - EOS accepted with idx==FRAME_LEN-1: no padding; sof_pending<=1.
  - EOS accepted with idx<FRAME_LEN-1: go to PAD; sof_pending<=1.
- State PAD: S_READY=0, PADDING=1.
  - Write PAD_VALUE each cycle the FIFO is not full, first=0.
  - On the pad write with idx==FRAME_LEN-1 (last=1): return to STREAM, idx=0.
- Read side: FIFO is first-word-fall-through. M_TVALID = !empty. M_TDATA/M_TLAST/M_TUSER come from the head entry.
  - Pop on M_TVALID&M_TREADY.
  - Outputs are held stable while M_TVALID&!M_TREADY (AXI rule).
- Latency: a sample written in cycle N is presented at cycle N+1 at the earliest.
- Full: S_READY low; a simultaneous pop does not open S_READY in the same cycle (no combinational ready path).
- Empty: a write and no read in the same cycle gives M_TVALID the next cycle.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged.
- Pointers are $clog2(DEPTH)+1 bits; full/empty are resolved by the MSB compare.
- FRAME_CNT increments on each M_TVALID&M_TREADY&M_TLAST and wraps 0xFFFF->0.
- S_EOS without S_VALID is ignored.
- TUSER marks only the first sample after reset or after each end-of-stream.

Decomposition:
- Package lpc_stream_pkg: state encoding (ST_STREAM, ST_PAD), a helper for the idx width, and the entry layout constant ENTRY_W = DATA_W+2.
- Sub-module lpc_sync_fifo (DATA_W=ENTRY_W, DEPTH; FWFT; full/empty outputs), reusable elsewhere in the encoder path.
- Framer top contains the tag logic, the STREAM/PAD FSM and FRAME_CNT.

Test Plan:
(FRAME_LEN=4, DEPTH=4, PAD_VALUE=0 unless noted)
- Continuous flow: samples 1..8, S_VALID=1, M_TREADY=1 -> outputs 1..8 in order; TUSER only on 1; TLAST on 4 and 8; FRAME_CNT=2; S_READY never drops.
- Backpressure: M_TREADY=0 for 10 cycles while feeding 1..6 -> exactly 4 accepted, then S_READY=0. After release, 1..6 emerge in order, with no loss, duplication or data change while stalled.
- EOS mid-frame: 0xA, 0xB(EOS) -> output A(TUSER), B, 0, 0(TLAST); PADDING high for 2 cycles; S_READY=0 meanwhile. Next sample 0xC carries TUSER=1.
- EOS on frame boundary: 1,2,3,4(EOS) -> TLAST on 4, no pad entries, PADDING never high; next sample has TUSER=1.
- Reset mid-frame: after 2 samples are accepted and 1 is output, assert ARESET for 1 cycle -> M_TVALID=0 immediately and FRAME_CNT=0. Next sample emerges with TUSER=1 and TLAST on the 4th post-reset sample.
- DEPTH=2, alternating M_TREADY -> full/empty boundaries are exercised; simultaneous push/pop keeps occupancy unchanged; the output order matches a scoreboard over 1000 random samples.

Source files
------------

// File: rtl/lpc_stream_pkg.sv
// Shared definitions for the LPC stream framer datapath.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package lpc_stream_pkg;

    // Write-side mode: pass input samples through, or fill out a frame with pad samples.
    typedef enum logic {
        ST_STREAM = 1'b0,
        ST_PAD    = 1'b1
    } state_t;

    // Each FIFO entry is laid out as {data, first, last}.
    localparam int TAG_W = 2;

    // Width of the in-frame sample index. It is never less than one bit.
    function automatic int idx_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

    // Entry width for a given sample width (ENTRY_W = DATA_W + 2).
    function automatic int entry_width(input int data_w);
        return data_w + TAG_W;
    endfunction

endpackage

// File: rtl/lpc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Latency: an entry pushed in cycle N is visible at o_pop_dat in cycle N+1.
// Backpressure: a push is ignored while o_full is high, and a pop is ignored while o_empty is high.
//
// Ports:
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_push, i_push_dat     write strobe and entry
//   i_pop                  consume the head entry
//   o_pop_dat              head entry (not meaningful while o_empty)
//   o_full, o_empty        occupancy flags
module lpc_sync_fifo #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_dat,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_dat,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    // The extra pointer MSB tells a full FIFO from an empty one when the address bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // The storage is not reset. The empty flag masks any stale contents.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/lpc_stream_framer.sv
// AXI-stream framer: tags PCM samples with first-of-stream and end-of-frame flags, and zero-pads a stream that ends mid-frame.
// Latency: an accepted sample is presented on M_* one cycle later at the earliest (FWFT buffer).
// Backpressure: S_READY follows the registered FIFO-full flag (no combinational path from M_TREADY) and is low while padding.
//
// Ports:
//   ACLK, ARESET                      clock, asynchronous active-high reset
//   S_DATA/S_VALID/S_EOS/S_READY      sample input. S_EOS is qualified by the handshake.
//   M_TDATA/M_TVALID/M_TREADY         AXI-stream output
//   M_TLAST/M_TUSER                   last sample of a frame / first sample of a stream
//   FRAME_CNT                         count of frames completed on the output (wraps)
//   PADDING                           high while pad samples are being written
module lpc_stream_framer
    import lpc_stream_pkg::*;
#(
    parameter int              DATA_W    = 16,
    parameter int              FRAME_LEN = 1920,
    parameter int              DEPTH     = 4,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DATA_W-1:0] S_DATA,
    input  logic              S_VALID,
    input  logic              S_EOS,
    output logic              S_READY,
    output logic [DATA_W-1:0] M_TDATA,
    output logic              M_TVALID,
    input  logic              M_TREADY,
    output logic              M_TLAST,
    output logic              M_TUSER,
    output logic [15:0]       FRAME_CNT,
    output logic              PADDING
);

    localparam int               IDX_W    = idx_width(FRAME_LEN);
    localparam int               ENTRY_W  = entry_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_sof;
    logic [15:0]        r_frame_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_last;
    logic               w_in_hs;
    logic [DATA_W-1:0]  w_wr_data;
    logic               w_wr_first;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_rd_entry;

    assign w_last     = (r_idx == LAST_IDX);
    assign S_READY    = !ARESET && (r_state == ST_STREAM) && !w_full;
    assign w_in_hs    = S_VALID && S_READY;
    assign w_wr_entry = {w_wr_data, w_wr_first, w_last};

    // Next state and the write-port mux. Pad writes carry first=0 and proceed whenever there is space.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_wr_data   = PAD_VALUE;
        w_wr_first  = 1'b0;
        case (r_state)
            ST_STREAM: begin
                w_push     = w_in_hs;
                w_wr_data  = S_DATA;
                w_wr_first = r_sof;
                // An EOS on the last index already closes the frame, so no padding is needed.
                if (w_in_hs && S_EOS && !w_last) w_state_nxt = ST_PAD;
            end
            ST_PAD: begin
                w_push = !w_full;
                if (!w_full && w_last) w_state_nxt = ST_STREAM;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= ST_STREAM;
            r_idx       <= '0;
            r_sof       <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push)  r_idx <= w_last ? '0 : r_idx + 1'b1;
            // An EOS rearms TUSER for the next stream. Any other accepted sample clears it.
            if (w_in_hs) r_sof <= S_EOS;
            if (w_pop && w_rd_entry[0]) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    lpc_sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk      (ACLK),
        .i_rst      (ARESET),
        .i_push     (w_push),
        .i_push_dat (w_wr_entry),
        .i_pop      (w_pop),
        .o_pop_dat  (w_rd_entry),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // The outputs are forced to zero while the FIFO is empty, so unwritten storage never reaches the port.
    assign w_pop     = !w_empty && M_TREADY;
    assign M_TVALID  = !w_empty;
    assign M_TDATA   = w_empty ? '0 : w_rd_entry[ENTRY_W-1:TAG_W];
    assign M_TUSER   = !w_empty && w_rd_entry[1];
    assign M_TLAST   = !w_empty && w_rd_entry[0];
    assign FRAME_CNT = r_frame_cnt;
    assign PADDING   = (r_state == ST_PAD);

endmodule

// File: tb/tb_lpc_stream_framer.sv
// Scoreboard bench for lpc_stream_framer: directed frames on a DEPTH=4 instance and a random stream on a DEPTH=2 instance.
// Latency: n/a.
// Backpressure: M_TREADY is driven directly (held low, pulsed, or alternated).
module tb_lpc_stream_framer;

    logic        ACLK = 1'b0;
    logic        ARESET;
    always #5 ACLK = ~ACLK;

    // Instance 1: FRAME_LEN=4, DEPTH=4
    logic [15:0] S_DATA, M_TDATA, FRAME_CNT;
    logic        S_VALID, S_EOS, S_READY, M_TVALID, M_TREADY, M_TLAST, M_TUSER, PADDING;
    // Instance 2: FRAME_LEN=4, DEPTH=2
    logic [15:0] s2_data, m2_tdata, frame_cnt2;
    logic        s2_valid, s2_eos, s2_ready, m2_tvalid, m2_tready, m2_tlast, m2_tuser, padding2;

    lpc_stream_framer #(.DATA_W(16), .FRAME_LEN(4), .DEPTH(4), .PAD_VALUE(16'h0000)) u_dut (
        .ACLK(ACLK), .ARESET(ARESET), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_EOS(S_EOS),
        .S_READY(S_READY), .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
        .M_TLAST(M_TLAST), .M_TUSER(M_TUSER), .FRAME_CNT(FRAME_CNT), .PADDING(PADDING)
    );

    lpc_stream_framer #(.DATA_W(16), .FRAME_LEN(4), .DEPTH(2), .PAD_VALUE(16'h0000)) u_dut2 (
        .ACLK(ACLK), .ARESET(ARESET), .S_DATA(s2_data), .S_VALID(s2_valid), .S_EOS(s2_eos),
        .S_READY(s2_ready), .M_TDATA(m2_tdata), .M_TVALID(m2_tvalid), .M_TREADY(m2_tready),
        .M_TLAST(m2_tlast), .M_TUSER(m2_tuser), .FRAME_CNT(frame_cnt2), .PADDING(padding2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];    // {data, tuser, tlast}, instance 1
    logic [17:0] exp2_q[$];   // same layout, instance 2
    logic [16:0] stim_q[$];   // {data, eos}, instance 1

    int acc_cnt = 0, stall_cnt = 0, pad_cnt = 0, pad_rdy_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic eos);
        stim_q.push_back({d, eos});
    endtask

    task automatic expect1(input logic [15:0] d, input logic f, input logic l);
        exp_q.push_back({d, f, l});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #2;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || stim_q.size() != 0) && n < 500) begin
            @(posedge ACLK);
            n++;
        end
        #2;
        check({name, "_drain"}, exp_q.size() + stim_q.size(), 0);
    endtask

    // Instance 1 driver: presents the head of stim_q and retires it on each handshake.
    initial begin : drv1
        logic hs;
        S_VALID = 1'b0; S_DATA = '0; S_EOS = 1'b0;
        forever begin
            @(negedge ACLK);
            hs = S_VALID && S_READY;
            if (S_VALID && !S_READY) stall_cnt++;
            if (PADDING) pad_cnt++;
            if (PADDING && S_READY) pad_rdy_bad++;
            @(posedge ACLK);
            #1;
            if (hs) begin
                void'(stim_q.pop_front());
                acc_cnt++;
            end
            if (stim_q.size() > 0) begin
                S_VALID = 1'b1;
                {S_DATA, S_EOS} = stim_q[0];
            end else begin
                S_VALID = 1'b0;
                S_EOS   = 1'b0;
            end
        end
    end

    // Instance 1 monitor: scoreboard compare on each output handshake, plus the hold-while-stalled rule.
    initial begin : mon1
        logic        prev_stall;
        logic [17:0] prev_out, cur, e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge ACLK);
            cur = {M_TDATA, M_TUSER, M_TLAST};
            if (ARESET) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("hold_stable", {M_TVALID, cur}, {1'b1, prev_out});
                if (M_TVALID && M_TREADY) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: actual 0x%0h required none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("out", cur, e);
                    end
                end
                prev_stall = M_TVALID && !M_TREADY;
                prev_out   = cur;
            end
        end
    end

    // Instance 2 monitor
    initial begin : mon2
        logic [17:0] e2;
        forever begin
            @(negedge ACLK);
            if (!ARESET && m2_tvalid && m2_tready) begin
                if (exp2_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL d2_unexpected_out: actual 0x%0h required none", m2_tdata);
                end else begin
                    e2 = exp2_q.pop_front();
                    check("d2_out", {m2_tdata, m2_tuser, m2_tlast}, e2);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a0, s0, p0, n;
        ARESET = 1'b1;
        M_TREADY = 1'b1;
        s2_valid = 1'b0; s2_eos = 1'b0; s2_data = '0; m2_tready = 1'b0;
        tick(2);
        check("rst_tvalid",  M_TVALID,  0);
        check("rst_tdata",   M_TDATA,   0);
        check("rst_tlast",   M_TLAST,   0);
        check("rst_tuser",   M_TUSER,   0);
        check("rst_sready",  S_READY,   0);
        check("rst_framecnt", FRAME_CNT, 0);
        check("rst_padding", PADDING,   0);
        ARESET = 1'b0;
        tick(1);

        // Continuous flow: 1..8, EOS on the frame boundary at 8
        s0 = stall_cnt;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), i == 8);
            expect1(16'(i), i == 1, (i % 4) == 0);
        end
        wait_drain("cont");
        check("cont_framecnt", FRAME_CNT, 2);
        check("cont_no_stall", stall_cnt - s0, 0);

        // Backpressure: 1..6 with EOS on 6, so the frame is padded with two zeros
        M_TREADY = 1'b0;
        a0 = acc_cnt;
        for (int i = 1; i <= 6; i++) send(16'(i), i == 6);
        expect1(16'd1, 1, 0); expect1(16'd2, 0, 0); expect1(16'd3, 0, 0); expect1(16'd4, 0, 1);
        expect1(16'd5, 0, 0); expect1(16'd6, 0, 0); expect1(16'd0, 0, 0); expect1(16'd0, 0, 1);
        tick(10);
        check("bp_accepted", acc_cnt - a0, 4);
        check("bp_sready_low", S_READY, 0);
        M_TREADY = 1'b1;
        wait_drain("bp");
        check("bp_framecnt", FRAME_CNT, 4);

        // EOS mid-frame: A, B(EOS) -> A, B, 0, 0(last). Then C(EOS) gets TUSER.
        p0 = pad_cnt;
        send(16'h000A, 0); send(16'h000B, 1);
        expect1(16'h000A, 1, 0); expect1(16'h000B, 0, 0); expect1(16'h0, 0, 0); expect1(16'h0, 0, 1);
        wait_drain("eos_mid");
        check("eos_mid_pad_cycles", pad_cnt - p0, 2);
        check("eos_mid_ready_in_pad", pad_rdy_bad, 0);
        send(16'h000C, 1);
        expect1(16'h000C, 1, 0); expect1(16'h0, 0, 0); expect1(16'h0, 0, 0); expect1(16'h0, 0, 1);
        wait_drain("eos_c");

        // EOS on the frame boundary: no pad entries, and the next sample is tagged first
        p0 = pad_cnt;
        for (int i = 1; i <= 4; i++) begin
            send(16'h0010 + 16'(i), i == 4);
            expect1(16'h0010 + 16'(i), i == 1, i == 4);
        end
        wait_drain("eos_bnd");
        check("eos_bnd_no_pad", pad_cnt - p0, 0);
        send(16'h0055, 1);
        expect1(16'h0055, 1, 0); expect1(16'h0, 0, 0); expect1(16'h0, 0, 0); expect1(16'h0, 0, 1);
        wait_drain("eos_bnd_next");
        check("eos_bnd_framecnt", FRAME_CNT, 8);

        // Reset mid-frame: two samples accepted and one output, then reset
        M_TREADY = 1'b0;
        a0 = acc_cnt;
        send(16'h0021, 0); send(16'h0022, 0);
        expect1(16'h0021, 1, 0);
        n = 0;
        while ((acc_cnt - a0) < 2 && n < 100) begin
            tick(1);
            n++;
        end
        check("rst_mid_accepted", acc_cnt - a0, 2);
        M_TREADY = 1'b1;
        tick(1);
        M_TREADY = 1'b0;
        check("rst_mid_one_out", exp_q.size(), 0);
        ARESET = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_tvalid", M_TVALID, 0);
        check("rst_mid_framecnt", FRAME_CNT, 0);
        tick(1);
        ARESET = 1'b0;
        M_TREADY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(16'h0030 + 16'(i), 0);
            expect1(16'h0030 + 16'(i), i == 1, i == 4);
        end
        wait_drain("rst_post");
        check("rst_post_framecnt", FRAME_CNT, 1);

        // DEPTH=2 instance: 1000 random samples, random S_VALID, alternating M_TREADY
        begin : d2
            int   sent, occ, cyc;
            logic hs_in, hs_out;
            sent = 0; occ = 0; cyc = 0;
            s2_data  = 16'($urandom);
            s2_valid = 1'b1;
            while (sent < 1000 && cyc < 20000) begin
                @(negedge ACLK);
                check("d2_sready_vs_occ", s2_ready, occ < 2);
                check("d2_tvalid_vs_occ", m2_tvalid, occ > 0);
                hs_in  = s2_valid && s2_ready;
                hs_out = m2_tvalid && m2_tready;
                if (hs_in) exp2_q.push_back({s2_data, sent == 0, (sent % 4) == 3});
                @(posedge ACLK);
                #1;
                occ = occ + int'(hs_in) - int'(hs_out);
                if (hs_in) begin
                    sent++;
                    s2_data = 16'($urandom);
                end
                s2_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                m2_tready = !m2_tready;
                cyc++;
            end
            s2_valid  = 1'b0;
            m2_tready = 1'b1;
            check("d2_all_sent", sent, 1000);
            n = 0;
            while (exp2_q.size() != 0 && n < 100) begin
                tick(1);
                n++;
            end
            tick(1);
            check("d2_drain", exp2_q.size(), 0);
            check("d2_framecnt", frame_cnt2, 250);
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
